// File: rtl/spawn_rng.sv
// Divider-paced 10-bit Fibonacci LFSR (x^10 + x^7 + 1) with a one-cycle tick per new value.
// Optional macro SPAWN_RNG_STEP_EN adds a step_req input that forces an immediate step.
module spawn_rng #(
    parameter int         TICK_DIV = 50000,
    parameter logic [9:0] SEED     = 10'b0000000001
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       load_seed,
    input  logic [9:0] seed_in,
`ifdef SPAWN_RNG_STEP_EN
    input  logic       step_req,
`endif
    output logic [9:0] rand_out,
    output logic       tick
);

    localparam int         CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
    localparam logic [9:0] SEED_SAFE = (SEED == 10'd0) ? 10'd1 : SEED;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   div_cnt;
    logic [CW-1:0]   div_cnt_next;
    logic [9:0]      rand_next;
    logic            tick_next;
    logic            run;
    logic            div_step;
    logic            force_step;
    logic            do_step;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            div_cnt  <= '0;
            rand_out <= SEED_SAFE;
            tick     <= 1'b0;
        end else begin
            state    <= state_next;
            div_cnt  <= div_cnt_next;
            rand_out <= rand_next;
            tick     <= tick_next;
        end
    end

`ifdef SPAWN_RNG_STEP_EN
    assign force_step = step_req;
`else
    assign force_step = 1'b0;
`endif

    always_comb begin
        state_next   = state;
        div_cnt_next = div_cnt;
        rand_next    = rand_out;
        tick_next    = 1'b0;

        case (state)
            IDLE:    if (enable)  state_next = RUN;
            RUN:     if (!enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // The edge that changes state already behaves as the new state,
        // so dropping enable freezes immediately and raising it counts at once.
        run      = (state_next == RUN);
        div_step = run && (div_cnt == CNT_MAX);
        do_step  = div_step || force_step;

        if (load_seed) begin
            rand_next    = (seed_in == 10'd0) ? 10'd1 : seed_in;
            div_cnt_next = '0;
        end else begin
            if (run) begin
                div_cnt_next = div_step ? '0 : div_cnt + CW'(1);
            end
            if (do_step) begin
                rand_next = {rand_out[8:0], rand_out[9] ^ rand_out[6]};
                tick_next = 1'b1;
            end
        end
    end

endmodule
